// File: rtl/truth_table_scan.sv
// rtl/truth_table_scan.sv - sequential truth-table extractor for small combinational functions
// Walks x = 0 .. 2**N-1, waits SETTLE+1 cycles per vector, then captures y into tt[x].

module truth_table_scan #(
   parameter int N      = 3,
   parameter int SETTLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              y,
   output logic [N-1:0]      x,
   output logic              busy,
   output logic              done,
   output logic              table_valid,
   output logic [2**N-1:0]   tt
);

   localparam logic [N-1:0] X_LAST     = '1;
   localparam logic [N-1:0] X_ONE      = N'(1);
   localparam logic [3:0]   SETTLE_CNT = 4'(SETTLE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_SAMPLE
   } state_t;

   state_t     state;
   logic [3:0] scnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         x           <= '0;
         tt          <= '0;
         scnt        <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         table_valid <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_WAIT;
                  x           <= '0;
                  scnt        <= SETTLE_CNT;
                  tt          <= '0;
                  table_valid <= 1'b0;
                  busy        <= 1'b1;
               end
            end
            // WAIT spans SETTLE+1 cycles so y has settled before SAMPLE.
            S_WAIT: begin
               if (scnt == 4'd0) begin
                  state <= S_SAMPLE;
               end else begin
                  scnt <= scnt - 4'd1;
               end
            end
            S_SAMPLE: begin
               tt[x] <= y;
               if (x == X_LAST) begin
                  state       <= S_IDLE;
                  done        <= 1'b1;
                  table_valid <= 1'b1;
                  busy        <= 1'b0;
                  x           <= '0;
               end else begin
                  x     <= x + X_ONE;
                  scnt  <= SETTLE_CNT;
                  state <= S_WAIT;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/truth_table_scan.md
# truth_table_scan

Sequential truth-table extractor for small combinational functions with up to 6 inputs, such as the 3-input gate and sum-of-products modules in the gate library. On `start` it walks every input vector `x = 0 .. 2**N-1`, waits a programmable settle time, samples the function output `y`, and packs the results into a `2**N`-bit minterm mask. It is the reader side of the combinational modules: they map inputs to `y`, and this block recovers the full function from `y`. It sits in the lab test harness between a controller (start/done) and one combinational block under test.

## Interface
- `N`, default 3: number of function inputs; legal range 1..6.
- `SETTLE`, default 1: idle cycles between driving a vector and sampling `y`; legal range 0..15.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  request a scan; sampled only in IDLE.
- `y`  in  1  output of the function under test; combinational from `x`.
- `x`  out  N  input vector driven to the function under test; registered.
- `busy`  out  1  high while a scan is in progress.
- `done`  out  1  one-cycle pulse when the scan completes.
- `table_valid`  out  1  high from completion until the next accepted `start` or reset.
- `tt`  out  2**N  truth table; bit `i` holds `y` sampled with `x == i`.

## Operation
- **States:** IDLE, WAIT, SAMPLE.
- **Internal registers:** settle counter `scnt`, width 4.
- **Reset** (`rst_n == 0` at an edge):
  - state goes to IDLE.
  - `x`, `tt`, `scnt` = 0.
  - `busy`, `done`, `table_valid` = 0.
  - Reset overrides every other input.
- **IDLE:**
  - `busy` = 0.
  - `x` holds 0.
  - `start == 1` moves the block to WAIT, and at that edge sets:
    - `x` = 0
    - `scnt` = SETTLE
    - `tt` = 0
    - `table_valid` = 0
    - `busy` = 1
  - `start == 0`: no change.
- **WAIT:**
  - If `scnt == 0`, go to SAMPLE.
  - Otherwise decrement `scnt`.
  - With SETTLE = 0, WAIT lasts exactly 1 cycle.
- **SAMPLE**, one cycle; at the edge leaving it, `tt[x]` is set to `y`, then:
  - If `x == 2**N-1` (terminal vector):
    - go to IDLE.
    - `done` = 1 for one cycle.
    - `table_valid` = 1.
    - `busy` = 0.
    - `x` = 0.
  - Otherwise:
    - `x` = `x + 1`.
    - `scnt` = SETTLE.
    - go to WAIT.
- **Arithmetic:**
  - `x` is unsigned N-bit.
  - The increment never wraps, because the terminal vector exits first.
  - Bit index into `tt` = `x` as unsigned.
- **`start` while busy (WAIT or SAMPLE):** ignored. No restart, no queueing.
- **`start` high in the same cycle `done` pulses:** the block is leaving SAMPLE, not in IDLE, so `start` is ignored. `start` is accepted on the following cycle if still high.
- **`tt` contents:**
  - `tt` is stable and meaningful only while `table_valid == 1`.
  - Partial bits are visible during a scan. Consumers must ignore them.
- **Reset mid-scan:** the scan is aborted, `tt` is cleared, and no `done` is produced.

## Timing
- **Per-vector cost:** SETTLE + 2 cycles (WAIT for SETTLE + 1 cycles, then SAMPLE for 1 cycle).
- **Settle margin:** `y` settles for SETTLE + 1 full cycles after `x` changes before it is sampled.
- **Latency:** with `start` accepted at edge k, `done` is high in the cycle after edge k + 2**N·(SETTLE+2).
  - N=3, SETTLE=1: `done` is high in the cycle after edge k+24.
  - N=3, SETTLE=0: `done` is high in the cycle after edge k+16.
- **`busy`:** high for exactly 2**N·(SETTLE+2) cycles per scan, and falls in the same cycle `done` rises.
- **`x` timing:** `x` changes only on the edge leaving SAMPLE. It is constant through each WAIT/SAMPLE pair.
- **Back-to-back scans:**
  - The minimum gap between `done` and the next accepted `start` is 1 cycle.
  - `table_valid` falls on the edge that accepts the new `start`.

## Test plan
- **SOP function.** N=3, SETTLE=1. `y = ~a&~b&~c | a&~b&~c | a&~b&c` with `{a,b,c} = x` (a is MSB). Pulse `start`.
  - Required: `tt == 8'h31`, `table_valid == 1`.
  - Required: `done` pulses exactly once, in the cycle after edge k+24.
- **Gate functions.** N=3, SETTLE=0, with `y` driven by each gate in turn, one scan per gate:
  - `y` = 3-input NAND → `tt == 8'h7F`.
  - `y` = 3-input AND → `tt == 8'h80`.
  - `y` = `~x[0]` → `tt == 8'h55`.
  - Required for each scan: `done` in the cycle after edge k+16.
  - Required for each scan: `busy` high for exactly 16 cycles.
- **Start while busy.** Hold `start` high for 40 cycles (N=3, SETTLE=1).
  - Required: first `done` in the cycle after edge k+24.
  - Required: `start` ignored during the `done` cycle.
  - Required: second scan accepted one cycle after `done`.
  - Required: `table_valid` low from that acceptance until the second `done`.
- **Reset mid-scan.** Assert `rst_n = 0` for 1 cycle during vector 5.
  - Required: next cycle `x == 0`, `tt == 0`, `busy == 0`, `table_valid == 0`.
  - Required: no `done` pulse.
  - Required: a new `start` then completes normally.
- **Parameter corners.**
  - N=1, SETTLE=15, `y = x[0]` → `tt == 2'b10`, `done` in the cycle after edge k+34.
  - N=6, SETTLE=0, `y = 1` → `tt == 64'hFFFF_FFFF_FFFF_FFFF`, `done` in the cycle after edge k+128.
